// File: rtl/layer_neuron_scheduler.sv
// layer_neuron_scheduler: shares one neuron-LUT evaluation port across every
// neuron of a sparse LogicNets layer. One activation vector is latched. For each
// neuron in turn, its FANIN taps are gathered into a LUT address, one request is
// issued and its result is collected. The finished output vector is then offered
// downstream.
// Optional feature macro: LUT_TIMEOUT_EN adds a response watchdog and the sticky
// err flag.
module layer_neuron_scheduler #(
  parameter int NEURONS = 8,
  parameter int INPUTS  = 16,
  parameter int FANIN   = 3,
  parameter int ABITS   = 2,
  parameter int OBITS   = 2,
  parameter logic [FANIN*NEURONS*$clog2(INPUTS)-1:0] CONN = '0,
  parameter int TIMEOUT = 15,
  localparam int NW = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [INPUTS*ABITS-1:0]   in_data,
  output logic                      lut_req_vld,
  input  logic                      lut_req_rdy,
  output logic [NW-1:0]             lut_neuron,
  output logic [FANIN*ABITS-1:0]    lut_addr,
  input  logic                      lut_rsp_vld,
  input  logic [OBITS-1:0]          lut_rsp_data,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [NEURONS*OBITS-1:0]  out_data,
  output logic                      err
);

  localparam int IW = $clog2(INPUTS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                     state, state_nxt;
  logic [NW-1:0]              cnt, cnt_nxt;
  logic [INPUTS*ABITS-1:0]    vec;
  logic [NEURONS*OBITS-1:0]   res;
  logic [IW-1:0]              tap;
  logic                       last;
  logic                       rsp_take;
  logic [OBITS-1:0]           rsp_val;

  assign last = (cnt == NW'(NEURONS - 1));

`ifdef LUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer;
  logic          expired;
  logic          err_q;

  // The watchdog fires on the TIMEOUT-th WAIT cycle that passes without a response.
  assign expired  = (state == WAIT) && !lut_rsp_vld && (timer == TW'(TIMEOUT - 1));
  // A watchdog expiry counts as a response whose value is zero.
  assign rsp_take = (state == WAIT) && (lut_rsp_vld || expired);
  assign rsp_val  = lut_rsp_vld ? lut_rsp_data : '0;
  assign err      = err_q;

  // Counts WAIT cycles. The count is held at zero outside WAIT, so every entry into WAIT starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      err_q <= 1'b0;
    end else begin
      if (state != WAIT) begin
        timer <= '0;
      end else if (!lut_rsp_vld && !expired) begin
        timer <= timer + 1'b1;
      end
      if (expired) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign rsp_take = (state == WAIT) && lut_rsp_vld;
  assign rsp_val  = lut_rsp_data;
  // Without the watchdog, err is a constant 0. The comparison is always false and only ties off TIMEOUT.
  assign err      = (TIMEOUT < 0);
`endif

  // State register, neuron counter, latched input vector and result slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      vec   <= '0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && in_vld) begin
        vec <= in_data;
      end
      if (rsp_take) begin
        res[int'(cnt)*OBITS +: OBITS] <= rsp_val;
      end
    end
  end

  // Sequencing: accept a vector, then issue and wait once per neuron, then offer the result.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (in_vld) begin
          state_nxt = ISSUE;
          cnt_nxt   = '0;
        end
      end
      ISSUE: begin
        if (lut_req_rdy) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (rsp_take) begin
          if (last) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt   = cnt + 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      DONE: begin
        if (out_rdy) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gathers the current neuron's taps from the latched vector into the LUT address.
  always_comb begin
    lut_addr = '0;
    tap      = '0;
    for (int f = 0; f < FANIN; f++) begin
      tap = CONN[(int'(cnt)*FANIN + f)*IW +: IW];
      if (int'(tap) < INPUTS) begin
        lut_addr[f*ABITS +: ABITS] = vec[int'(tap)*ABITS +: ABITS];
      end
    end
  end

  // Handshake flags come straight from the state, so they cannot depend combinationally on the inputs.
  always_comb begin
    in_rdy      = (state == IDLE);
    lut_req_vld = (state == ISSUE);
    out_vld     = (state == DONE);
    lut_neuron  = cnt;
    out_data    = res;
  end

endmodule

// File: tb/tb_layer_neuron_scheduler.sv
// tb_layer_neuron_scheduler: drives layer_neuron_scheduler (2 neurons, 4 inputs)
// with directed and randomized traffic. Outputs are compared every cycle against a
// transaction-level reference model of the scheduler.
module tb_layer_neuron_scheduler;

  localparam int N   = 2;
  localparam int IN  = 4;
  localparam int F   = 3;
  localparam int A   = 2;
  localparam int O   = 2;
  localparam int TMO = 15;
  // neuron0 taps {0,1,2}, neuron1 taps {3,2,1}
  localparam logic [11:0] CONN_TB = 12'b01_10_11_10_01_00;

  logic         clk;
  logic         rst_n;
  logic         in_vld;
  logic         in_rdy;
  logic [7:0]   in_data;
  logic         lut_req_vld;
  logic         lut_req_rdy;
  logic [0:0]   lut_neuron;
  logic [5:0]   lut_addr;
  logic         lut_rsp_vld;
  logic [1:0]   lut_rsp_data;
  logic         out_vld;
  logic         out_rdy;
  logic [3:0]   out_data;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder bookkeeping for the randomized LUT model.
  bit pending;
  int due;

  layer_neuron_scheduler #(
    .NEURONS(N), .INPUTS(IN), .FANIN(F), .ABITS(A), .OBITS(O),
    .CONN(CONN_TB), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .lut_req_vld(lut_req_vld), .lut_req_rdy(lut_req_rdy),
    .lut_neuron(lut_neuron), .lut_addr(lut_addr),
    .lut_rsp_vld(lut_rsp_vld), .lut_rsp_data(lut_rsp_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .err(err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int taps [N][F] = '{'{0, 1, 2}, '{3, 2, 1}};

  function automatic logic [5:0] modelAddr(input logic [7:0] v, input int n);
    logic [5:0] a;
    a = '0;
    for (int f = 0; f < F; f++) a[f*A +: A] = v[taps[n][f]*A +: A];
    return a;
  endfunction

  logic [7:0] m_vec;
  logic [3:0] m_out;
  bit         m_busy, m_req_out, m_fin, m_err;
  int         m_cnt, m_wait;
  logic       m_timed;

  // Marks a watchdog expiry: the TIMEOUT-th WAIT cycle in a row without a response.
  always_comb begin
    m_timed = 1'b0;
`ifdef LUT_TIMEOUT_EN
    m_timed = !lut_rsp_vld && (m_wait + 1 >= TMO);
`endif
  end

  // Tracks the transaction: which vector is held, how many neurons are resolved, and whether a request is outstanding.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vec <= '0; m_out <= '0; m_busy <= 0; m_req_out <= 0; m_fin <= 0;
      m_err <= 0; m_cnt <= 0; m_wait <= 0;
    end else if (!m_busy) begin
      if (in_vld) begin
        m_vec <= in_data; m_busy <= 1; m_cnt <= 0; m_req_out <= 0; m_fin <= 0;
      end
    end else if (m_fin) begin
      if (out_rdy) begin
        m_busy <= 0; m_fin <= 0; m_cnt <= 0;
      end
    end else if (!m_req_out) begin
      if (lut_req_rdy) begin
        m_req_out <= 1; m_wait <= 0;
      end
    end else if (lut_rsp_vld || m_timed) begin
      m_out[m_cnt*O +: O] <= lut_rsp_vld ? lut_rsp_data : 2'b00;
      m_req_out <= 0;
      if (m_timed) m_err <= 1;
      if (m_cnt == N - 1) m_fin <= 1;
      else m_cnt <= m_cnt + 1;
    end else begin
      m_wait <= m_wait + 1;
    end
  end

  // Compares every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("in_rdy", in_rdy, !m_busy);
    checkOutput("lut_req_vld", lut_req_vld, m_busy && !m_fin && !m_req_out);
    if (m_busy && !m_fin && !m_req_out) begin
      checkOutput("lut_neuron", lut_neuron, m_cnt);
      checkOutput("lut_addr", lut_addr, modelAddr(m_vec, m_cnt));
    end
    checkOutput("out_vld", out_vld, m_fin);
    checkOutput("out_data", out_data, m_out);
    checkOutput("err", err, m_err);
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus();
    @(negedge clk);
    lut_rsp_vld  = 1'b0;
    lut_rsp_data = 2'($urandom);
    if (pending) begin
      if (due == 0) begin
        lut_rsp_vld = 1'b1;
        pending = 0;
      end else begin
        due--;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      lut_rsp_vld = 1'b1;
    end
    lut_req_rdy = ($urandom_range(0, 99) < 60);
    if (lut_req_vld && lut_req_rdy) begin
      pending = 1;
      due = $urandom_range(0, 2);
    end
    out_rdy = ($urandom_range(0, 99) < 50);
    in_vld  = ($urandom_range(0, 99) < 40);
    in_data = 8'($urandom);
  endtask

  task automatic drainToIdle();
    int k;
    k = 0;
    in_vld = 1'b0;
    while (!in_rdy && k < 300) begin
      applyStimulus();
      in_vld = 1'b0;
      out_rdy = 1'b1;
      k++;
    end
    @(negedge clk);
    checkOutput("drain_idle", in_rdy, 1);
    lut_rsp_vld = 1'b0;
    pending = 0;
  endtask

  task automatic runExample();
    int first;
    logic [3:0] seen;
    first = 0;
    seen = '0;
    in_vld = 1'b1; in_data = 8'b11_10_01_00; lut_req_rdy = 1'b1; out_rdy = 1'b1; lut_rsp_vld = 1'b0;
    for (int c = 1; c <= 12 && first == 0; c++) begin
      @(negedge clk);
      in_vld = 1'b0;
      lut_rsp_vld = 1'b0;
      if (c == 2) begin lut_rsp_vld = 1'b1; lut_rsp_data = 2'b01; end
      if (c == 4) begin lut_rsp_vld = 1'b1; lut_rsp_data = 2'b11; end
      if (c == 1) begin
        checkOutput("ex_addr_n0", lut_addr, 6'b100100);
        checkOutput("ex_neuron_n0", lut_neuron, 0);
      end
      if (c == 3) begin
        checkOutput("ex_addr_n1", lut_addr, 6'b011011);
        checkOutput("ex_neuron_n1", lut_neuron, 1);
      end
      if (out_vld) begin
        first = c;
        seen = out_data;
      end
    end
    checkOutput("ex_latency", first, 5);
    checkOutput("ex_out_data", seen, 4'b1101);
    @(negedge clk);
    lut_rsp_vld = 1'b0;
    checkOutput("ex_back_idle", in_rdy, 1);
  endtask

  task automatic runBackpressure();
    in_vld = 1'b1; in_data = 8'b00_11_01_10; lut_req_rdy = 1'b0; out_rdy = 1'b0; lut_rsp_vld = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      in_vld = 1'b0;
      lut_rsp_vld = (c == 2);
      lut_rsp_data = 2'b11;
      checkOutput("hold_req_vld", lut_req_vld, 1);
      checkOutput("hold_neuron", lut_neuron, 0);
      checkOutput("hold_addr", lut_addr, 6'b110110);
    end
    @(negedge clk);
    lut_rsp_vld = 1'b0;
    lut_req_rdy = 1'b1;
    @(negedge clk);
    lut_rsp_vld = 1'b1; lut_rsp_data = 2'b10;
    @(negedge clk);
    lut_rsp_vld = 1'b0;
    checkOutput("bp_addr_n1", lut_addr, 6'b011100);
    checkOutput("bp_neuron_n1", lut_neuron, 1);
    @(negedge clk);
    lut_rsp_vld = 1'b1; lut_rsp_data = 2'b01;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      lut_rsp_vld = 1'b0;
      in_vld = 1'b1; in_data = 8'b11_10_01_00;
      checkOutput("done_out_vld", out_vld, 1);
      checkOutput("done_out_data", out_data, 4'b0110);
      checkOutput("done_in_rdy", in_rdy, 0);
    end
    @(negedge clk);
    out_rdy = 1'b1;
    checkOutput("done_release_vld", out_vld, 1);
    @(negedge clk);
    checkOutput("b2b_in_rdy", in_rdy, 1);
    @(negedge clk);
    in_vld = 1'b0;
    lut_req_rdy = 1'b0;
    checkOutput("b2b_req_vld", lut_req_vld, 1);
    checkOutput("b2b_addr", lut_addr, 6'b100100);
  endtask

  task automatic runResetMidWait();
    in_vld = 1'b1; in_data = 8'b01_01_10_10; lut_req_rdy = 1'b1; out_rdy = 1'b1; lut_rsp_vld = 1'b0;
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_wait", lut_req_vld, 0);
    #2;
    rst_n = 1'b0;
    lut_rsp_vld = 1'b1; lut_rsp_data = 2'b11;
    @(negedge clk);
    checkOutput("rst_in_rdy", in_rdy, 1);
    checkOutput("rst_req_vld", lut_req_vld, 0);
    checkOutput("rst_out_vld", out_vld, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    lut_rsp_vld = 1'b0;
    checkOutput("rst_rsp_ignored_rdy", in_rdy, 1);
    checkOutput("rst_rsp_ignored_data", out_data, 0);
    pending = 0;
  endtask

`ifdef LUT_TIMEOUT_EN
  task automatic runTimeout();
    int waits;
    waits = 0;
    in_vld = 1'b1; in_data = 8'b10_01_11_00; lut_req_rdy = 1'b1; out_rdy = 1'b0; lut_rsp_vld = 1'b0;
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    lut_rsp_vld = 1'b1; lut_rsp_data = 2'b10;
    @(negedge clk);
    lut_rsp_vld = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_vld) break;
      waits++;
    end
    checkOutput("tmo_wait_cycles", waits, 15);
    checkOutput("tmo_slot1", out_data[3:2], 2'b00);
    checkOutput("tmo_slot0", out_data[1:0], 2'b10);
    checkOutput("tmo_err", err, 1);
    out_rdy = 1'b1;
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_data = '0; lut_req_rdy = 1'b0;
    lut_rsp_vld = 1'b0; lut_rsp_data = '0; out_rdy = 1'b0;
    pending = 0; due = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_rdy", in_rdy, 1);
    checkOutput("reset_req_vld", lut_req_vld, 0);
    checkOutput("reset_neuron", lut_neuron, 0);
    checkOutput("reset_addr", lut_addr, 0);
    checkOutput("reset_out_vld", out_vld, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_err", err, 0);
    rst_n = 1'b1;

    $display("[TB] directed example transaction");
    runExample();
    $display("[TB] request and output backpressure");
    runBackpressure();
    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) applyStimulus();
    drainToIdle();
    $display("[TB] reset during WAIT");
    runResetMidWait();
    for (int i = 0; i < 300; i++) applyStimulus();
    drainToIdle();
`ifdef LUT_TIMEOUT_EN
    $display("[TB] LUT response watchdog");
    runTimeout();
    drainToIdle();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
